// File: rtl/imm_gen_stage.sv
// imm_gen_stage: pipelined RV32I immediate generator with a 2-entry skid buffer.
// The instruction is decoded as it arrives. The decoded immediate, format tag
// and illegal flag are stored in a main output register. A skid register
// catches one more entry while the output is stalled, so a stall costs no
// throughput.
// Ports:
//   i_clk, i_rst_n      clock (rising edge) and asynchronous active-low reset
//   i_valid/o_ready     upstream handshake; o_ready is registered
//   i_instr[31:0]       instruction word
//   o_valid/i_ready     downstream handshake
//   o_imm[XLEN-1:0]     sign-extended immediate
//   o_fmt[2:0]          0=R 1=I 2=S 3=B 4=U 5=J 7=none
//   o_illegal           opcode not recognised

// Sign extender: copies in[N-1] into bits M-1:N.
module signext #(
  parameter int N = 12,
  parameter int M = 32
) (
  input  logic [N-1:0] in,
  output logic [M-1:0] out
);
  if (M == N) begin : g_same
    assign out = in;
  end else begin : g_ext
    assign out = {{(M-N){in[N-1]}}, in};
  end
endmodule

module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  localparam ent_t RST_ENT = '{imm: '0, fmt: 3'd7, ill: 1'b0};

  logic [XLEN-1:0] sx_i, sx_s, sx_b, sx_u, sx_j;

  signext #(.N(12), .M(XLEN)) u_sx_i (.in(i_instr[31:20]), .out(sx_i));
  signext #(.N(12), .M(XLEN)) u_sx_s (.in({i_instr[31:25], i_instr[11:7]}), .out(sx_s));
  signext #(.N(13), .M(XLEN)) u_sx_b (
    .in({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}), .out(sx_b));
  signext #(.N(32), .M(XLEN)) u_sx_u (.in({i_instr[31:12], 12'b0}), .out(sx_u));
  signext #(.N(21), .M(XLEN)) u_sx_j (
    .in({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}), .out(sx_j));

  ent_t dec;

  always_comb begin
    dec = '{imm: '0, fmt: 3'd7, ill: 1'b1};
    case (i_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec = '{imm: sx_i, fmt: 3'd1, ill: 1'b0};
      7'b0100011:             dec = '{imm: sx_s, fmt: 3'd2, ill: 1'b0};
      7'b1100011:             dec = '{imm: sx_b, fmt: 3'd3, ill: 1'b0};
      7'b0110111, 7'b0010111: dec = '{imm: sx_u, fmt: 3'd4, ill: 1'b0};
      7'b1101111:             dec = '{imm: sx_j, fmt: 3'd5, ill: 1'b0};
      7'b0110011:             dec = '{imm: '0,   fmt: 3'd0, ill: 1'b0};
      default: ;
    endcase
  end

  logic [1:0] state, nxt;
  ent_t       main_q, skid_q;
  logic       in_xfer, out_xfer, ld_main, ld_skid, mv_skid;

  assign o_valid   = (state != EMPTY);
  assign in_xfer   = i_valid & o_ready;
  assign out_xfer  = o_valid & i_ready;
  assign o_imm     = main_q.imm;
  assign o_fmt     = main_q.fmt;
  assign o_illegal = main_q.ill;

  always_comb begin
    nxt     = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    case (state)
      EMPTY: if (in_xfer) begin
        nxt     = ONE;
        ld_main = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) ld_main = 1'b1;
        else if (in_xfer) begin
          nxt     = FULL;
          ld_skid = 1'b1;
        end else if (out_xfer) nxt = EMPTY;
      end
      FULL: if (out_xfer) begin
        nxt     = ONE;
        mv_skid = 1'b1;
      end
      default: nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= EMPTY;
      main_q  <= RST_ENT;
      skid_q  <= RST_ENT;
      o_ready <= 1'b1;
    end else begin
      state   <= nxt;
      // Ready is registered from the next state so it never depends on i_ready.
      o_ready <= (nxt != FULL);
      if (ld_main)      main_q <= dec;
      else if (mv_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= dec;
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
module tb_imm_gen_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [31:0]     i_instr = '0;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [XLEN-1:0] o_imm;
  logic [2:0]      o_fmt;
  logic            o_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .o_valid(o_valid), .i_ready(i_ready),
    .o_imm(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode using signed shifts on a 64-bit copy of the word.
  function automatic logic [2:0] ref_fmt(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 3'd1;
      7'h23: return 3'd2;
      7'h63: return 3'd3;
      7'h37, 7'h17: return 3'd4;
      7'h6F: return 3'd5;
      7'h33: return 3'd0;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] w);
    longint sx, u, r;
    sx = longint'($signed(w));
    u  = longint'(w);
    case (ref_fmt(w))
      3'd1: r = sx >>> 20;
      3'd2: r = ((sx >>> 25) << 5) | ((u >> 7) & 'h1F);
      3'd3: r = ((sx >>> 31) << 12) | (((u >> 7) & 1) << 11) |
                (((u >> 25) & 'h3F) << 5) | (((u >> 8) & 'hF) << 1);
      3'd4: r = sx & ~longint'('hFFF);
      3'd5: r = ((sx >>> 31) << 20) | (((u >> 12) & 'hFF) << 12) |
                (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3FF) << 1);
      default: r = 0;
    endcase
    return r[XLEN-1:0];
  endfunction

  task automatic chk_out(input string tag, input logic [31:0] w);
    chk({tag, ".imm"}, 64'(o_imm), 64'(ref_imm(w)));
    chk({tag, ".fmt"}, 64'(o_fmt), 64'(ref_fmt(w)));
    chk({tag, ".ill"}, 64'(o_illegal), 64'(ref_fmt(w) == 3'd7));
  endtask

  // One instruction through with i_ready=1; checks literal expected values.
  task automatic send1(input string tag, input logic [31:0] w,
                       input logic [31:0] e_imm, input logic [2:0] e_fmt, input logic e_ill);
    @(negedge clk);
    i_valid = 1'b1; i_instr = w; i_ready = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_instr = $urandom;
    chk({tag, ".vld"}, 64'(o_valid), 64'd1);
    chk({tag, ".imm"}, 64'(o_imm), 64'(e_imm));
    chk({tag, ".fmt"}, 64'(o_fmt), 64'(e_fmt));
    chk({tag, ".ill"}, 64'(o_illegal), 64'(e_ill));
    @(negedge clk);
    chk({tag, ".drain"}, 64'(o_valid), 64'd0);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  logic [31:0] q[$];
  logic [31:0] a, b, c;

  initial begin
    #12;
    chk("rst.vld", 64'(o_valid), 64'd0);
    chk("rst.rdy", 64'(o_ready), 64'd1);
    chk("rst.imm", 64'(o_imm), 64'd0);
    chk("rst.fmt", 64'(o_fmt), 64'd7);
    chk("rst.ill", 64'(o_illegal), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    send1("addi", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    send1("sw",   32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
    send1("jal",  32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0);
    send1("lui",  32'h800002B7, 32'h80000000, 3'd4, 1'b0);
    send1("ill",  32'h0000007F, 32'h00000000, 3'd7, 1'b1);
    send1("add",  32'h002081B3, 32'h00000000, 3'd0, 1'b0);

    // Backpressure: A and B accepted, C stalled, then in-order drain.
    a = 32'h00500093; b = 32'hFE000EE3; c = 32'h123450B7;
    @(negedge clk); i_ready = 1'b0; i_valid = 1'b1; i_instr = a;
    @(negedge clk); i_instr = b;
    @(negedge clk); chk("bp.rdy0", 64'(o_ready), 64'd0); i_instr = c;
    @(negedge clk);
    chk("bp.rdy1", 64'(o_ready), 64'd0);
    chk("bp.vld", 64'(o_valid), 64'd1);
    chk_out("bp.a", a);
    i_ready = 1'b1;
    @(negedge clk); chk_out("bp.b", b); chk("bp.rdy2", 64'(o_ready), 64'd1);
    @(negedge clk); chk_out("bp.c", c); i_valid = 1'b0;
    @(negedge clk); chk("bp.empty", 64'(o_valid), 64'd0);

    // Reset mid-cycle while FULL.
    i_ready = 1'b0; i_valid = 1'b1; i_instr = a;
    @(negedge clk); i_instr = b;
    @(negedge clk); i_valid = 1'b0;
    chk("rf.full", 64'(o_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rf.vld", 64'(o_valid), 64'd0);
    chk("rf.rdy", 64'(o_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1; i_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rf.stale", 64'(o_valid), 64'd0);
    end

    // Random traffic against a FIFO model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic ix, ox;
      chk("rnd.vld", 64'(o_valid), 64'(q.size() > 0));
      chk("rnd.rdy", 64'(o_ready), 64'(q.size() < 2));
      if (q.size() > 0 && o_valid) chk_out("rnd", q[0]);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 2) != 0);
      i_instr = rnd_instr();
      ix = i_valid && (q.size() < 2);
      ox = i_ready && (q.size() > 0);
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(i_instr);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
